exhaustive_vector_checker: RTL

Synthesizable successor to our hand-written exhaustive truth-table benches. It sweeps every input combination of a WIDTH-input combinational or pipelined DUT, compares each DUT response against a parameterised expected table, counts mismatches and records the first failing vector. It sits between a sequencer or test controller and the DUT, and uses a start/busy/done handshake.

---
 rtl/exhaustive_vector_checker_pkg.sv | 22 ++
 rtl/exhaustive_vector_checker_vec_delay_line.sv | 49 ++++
 rtl/exhaustive_vector_checker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/exhaustive_vector_checker_pkg.sv
// Shared types and helpers for the exhaustive vector checker and its delay line.
package exhaustive_vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    // Widest supported sweep; helpers work at this width and callers truncate.
    localparam int MAX_W = 16;

    function automatic logic [MAX_W-1:0] to_gray(input logic [MAX_W-1:0] idx);
        return idx ^ (idx >> 1);
    endfunction

    function automatic int num_vectors(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/exhaustive_vector_checker_vec_delay_line.sv
// Delays {valid, pattern} by LAT cycles so the comparison lines up with a
// pipelined DUT response; LAT=0 is a plain wire.
module vec_delay_line
    import exhaustive_vector_checker_pkg::*;
#(
    parameter int LAT   = 0,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_pattern,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_pattern
);

    generate
        if (LAT == 0) begin : g_pass
            logic w_unused;
            assign w_unused  = ^{i_clk, i_rst, i_flush};
            assign o_valid   = i_valid;
            assign o_pattern = i_pattern;
        end else begin : g_shift
            logic [LAT-1:0]   r_valid;
            logic [WIDTH-1:0] r_pat [LAT];

            // A flush drops every in-flight vector so an aborted sweep leaves nothing to compare.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_valid <= '0;
                    for (int i = 0; i < LAT; i++) r_pat[i] <= '0;
                end else begin
                    r_valid[0] <= i_valid;
                    r_pat[0]   <= i_pattern;
                    for (int i = 1; i < LAT; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_pat[i]   <= r_pat[i-1];
                    end
                    if (i_flush) r_valid <= '0;
                end
            end

            assign o_valid   = r_valid[LAT-1];
            assign o_pattern = r_pat[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Sweeps all 2**WIDTH input vectors into a DUT, checks each response against
// EXP_TABLE, counts mismatches and captures the first failing input.
module exhaustive_vector_checker
    import exhaustive_vector_checker_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int OUT_W = 1,
    parameter int LAT   = 0,
    parameter int GRAY  = 0,
    parameter logic [OUT_W*(2**WIDTH)-1:0] EXP_TABLE = 8'hE8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_pattern,
    output logic             o_pattern_valid,
    input  logic [OUT_W-1:0] i_resp,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [WIDTH:0]   o_err_count,
    output logic [WIDTH-1:0] o_first_fail,
    output logic             o_first_fail_valid
);

    localparam int NVEC  = num_vectors(WIDTH);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NVEC - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_idx;
    logic [WIDTH-1:0]   w_idx_next;
    logic [WIDTH-1:0]   w_next_pattern;
    logic [CNT_W-1:0]   r_drain_cnt;
    logic [WIDTH-1:0]   r_pattern;
    logic               r_pattern_valid;
    logic [WIDTH:0]     r_err_count;
    logic [WIDTH-1:0]   r_first_fail;
    logic               r_first_fail_valid;
    logic               r_pass;
    logic               w_flush;
    logic               w_dly_valid;
    logic [WIDTH-1:0]   w_dly_pattern;
    logic [OUT_W*NVEC-1:0] w_tbl_shift;
    logic [OUT_W-1:0]   w_expected;
    logic               w_mismatch;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_next = RUN;
            RUN: begin
                if (i_abort)                  w_state_next = IDLE;
                else if (r_idx == LAST_IDX)   w_state_next = (LAT > 0) ? DRAIN : FIN;
            end
            DRAIN: begin
                if (i_abort)                               w_state_next = IDLE;
                else if (r_drain_cnt == CNT_W'(LAT - 1))   w_state_next = FIN;
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_idx_next     = r_idx + 1'b1;
    assign w_next_pattern = (GRAY != 0) ? WIDTH'(to_gray(MAX_W'(w_idx_next))) : w_idx_next;

    // pattern_valid simply tracks whether the next cycle is still a RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx           <= '0;
            r_pattern       <= '0;
            r_pattern_valid <= 1'b0;
            r_drain_cnt     <= '0;
        end else begin
            r_pattern_valid <= (w_state_next == RUN);
            if (r_state == IDLE && i_start) begin
                r_idx       <= '0;
                r_pattern   <= '0;
                r_drain_cnt <= '0;
            end else if (r_state == RUN && w_state_next == RUN) begin
                r_idx     <= w_idx_next;
                r_pattern <= w_next_pattern;
            end else if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    assign w_flush = i_abort && (r_state == RUN || r_state == DRAIN);

    vec_delay_line #(
        .LAT   (LAT),
        .WIDTH (WIDTH)
    ) u_delay (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (w_flush),
        .i_valid   (r_pattern_valid),
        .i_pattern (r_pattern),
        .o_valid   (w_dly_valid),
        .o_pattern (w_dly_pattern)
    );

    // The table is indexed by the applied input value, so Gray order needs no remapping.
    assign w_tbl_shift = EXP_TABLE >> (int'(w_dly_pattern) * OUT_W);
    assign w_expected  = w_tbl_shift[OUT_W-1:0];
    assign w_mismatch  = w_dly_valid && (i_resp != w_expected);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else if (r_state == IDLE && i_start) begin
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
        end else begin
            if (w_mismatch) begin
                r_err_count <= r_err_count + 1'b1;
                if (!r_first_fail_valid) begin
                    r_first_fail       <= w_dly_pattern;
                    r_first_fail_valid <= 1'b1;
                end
            end
            if (r_state == FIN) r_pass <= (r_err_count == '0);
        end
    end

    assign o_pattern          = r_pattern;
    assign o_pattern_valid    = r_pattern_valid;
    assign o_busy             = (r_state == RUN) || (r_state == DRAIN);
    assign o_done             = (r_state == FIN);
    assign o_pass             = (r_state == FIN) ? (r_err_count == '0) : r_pass;
    assign o_err_count        = r_err_count;
    assign o_first_fail       = r_first_fail;
    assign o_first_fail_valid = r_first_fail_valid;

endmodule
